// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter core between NUM_REQ byte streams.
// A grant is held for a whole packet, or until MAX_PKT bytes have gone out.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_PKT = 16
) (
  input  logic                      tx_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      core_valid,
  output logic [DATA_W-1:0]         core_data,
  input  logic                      core_ready,
  input  logic                      core_done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        pkt_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   cand;
  logic               arb_found;
  logic [7:0]         byte_cnt;
  logic               last_r;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;

  // First valid requester after last_gnt, wrapping modulo NUM_REQ.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_gnt) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_idx   = cand;
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign core_valid = (state == ISSUE) && sel_valid;
  assign core_data  = (state == ISSUE) ? sel_data : '0;
  assign req_ready  = ((state == ISSUE) && core_ready) ? grant : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      gnt_idx  <= '0;
      last_gnt <= IDX_W'(NUM_REQ - 1);
      byte_cnt <= '0;
      last_r   <= 1'b0;
      pkt_done <= '0;
    end else begin
      pkt_done <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant    <= NUM_REQ'(1) << arb_idx;
            gnt_idx  <= arb_idx;
            byte_cnt <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_valid && core_ready) begin
            last_r   <= sel_last;
            byte_cnt <= byte_cnt + 8'd1;
            state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (core_done) begin
            if (last_r) begin
              pkt_done <= grant;
              last_gnt <= gnt_idx;
              grant    <= '0;
              state    <= IDLE;
            end else if (byte_cnt == 8'(MAX_PKT)) begin
              // Forced release mid-packet: the owner re-arbitrates for the rest.
              last_gnt <= gnt_idx;
              grant    <= '0;
              state    <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a framed core model,
// expected byte/owner and pkt_done queues filled as stimulus is loaded.
module tb_uart_tx_arbiter;

  localparam int unsigned NR     = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned FRAME  = 10;
  localparam int unsigned BUDGET = 3000;

  logic              tx_clk  = 1'b0;
  logic              reset_n = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic              cr, cd, sel;
  logic              cr_a, cd_a, cr_b, cd_b;
  logic [NR-1:0]     rr_a, gnt_a, pd_a, rr_b, gnt_b, pd_b;
  logic              cv_a, cv_b, busy_a, busy_b;
  logic [DW-1:0]     cdat_a, cdat_b;
  logic [NR-1:0]     m_rr, m_gnt, m_pd;
  logic              m_cv, m_busy;
  logic [DW-1:0]     m_cdat;

  always #5 tx_clk = ~tx_clk;

  // Instance a: default MAX_PKT; instance b: MAX_PKT=2. Only the selected one sees the core.
  assign cr_a   = cr & ~sel;
  assign cd_a   = cd & ~sel;
  assign cr_b   = cr & sel;
  assign cd_b   = cd & sel;
  assign m_rr   = sel ? rr_b   : rr_a;
  assign m_gnt  = sel ? gnt_b  : gnt_a;
  assign m_pd   = sel ? pd_b   : pd_a;
  assign m_cv   = sel ? cv_b   : cv_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_cdat = sel ? cdat_b : cdat_a;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_PKT(16)) dut_a (
    .tx_clk(tx_clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rr_a), .core_valid(cv_a), .core_data(cdat_a),
    .core_ready(cr_a), .core_done(cd_a), .grant(gnt_a), .busy(busy_a), .pkt_done(pd_a)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_PKT(2)) dut_b (
    .tx_clk(tx_clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rr_b), .core_valid(cv_b), .core_data(cdat_b),
    .core_ready(cr_b), .core_done(cd_b), .grant(gnt_b), .busy(busy_b), .pkt_done(pd_b)
  );

  logic [DW-1:0] bdata [NR][8];
  logic          blast [NR][8];
  int unsigned   bgap  [NR][8];
  int unsigned   bcnt  [NR];
  int unsigned   bpos  [NR];
  int unsigned   bwait [NR];
  int unsigned   fcnt;
  logic          in_frame, prev_cd;
  logic [15:0]   exp_q[$];
  int unsigned   done_q[$];
  int unsigned   checks = 0;
  int unsigned   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int unsigned r, input logic [DW-1:0] d, input logic l,
                      input int unsigned gap);
    bdata[r][bcnt[r]] = d;
    blast[r][bcnt[r]] = l;
    bgap[r][bcnt[r]]  = gap;
    bcnt[r]++;
  endtask

  task automatic expect_byte(input int unsigned owner, input logic [DW-1:0] d);
    exp_q.push_back({8'(owner), d});
  endtask

  task automatic do_reset(input logic s);
    sel       = s;
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    cr        = 1'b1;
    cd        = 1'b0;
    fcnt      = 0;
    in_frame  = 1'b0;
    prev_cd   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bcnt[i]  = 0;
      bpos[i]  = 0;
      bwait[i] = 0;
    end
    exp_q.delete();
    done_q.delete();
    #1;
    check("rst_grant", 32'(m_gnt), 32'(0));
    check("rst_busy", 32'(m_busy), 32'(0));
    check("rst_core_valid", 32'(m_cv), 32'(0));
    check("rst_req_ready", 32'(m_rr), 32'(0));
    check("rst_pkt_done", 32'(m_pd), 32'(0));
    check("rst_core_data", 32'(m_cdat), 32'(0));
    repeat (2) @(posedge tx_clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic cycle();
    logic [NR-1:0] acc;
    logic [NR-1:0] oh;
    logic          hs;
    logic [15:0]   e;
    int unsigned   d;
    @(negedge tx_clk);
    check("grant_onehot", 32'($onehot0(m_gnt)), 32'(1));
    check("busy", 32'(m_busy), 32'(|m_gnt));
    check("ready_owner", 32'(m_rr & ~m_gnt), 32'(0));
    check("core_valid", 32'(m_cv), 32'((|(req_valid & m_gnt)) & ~in_frame));
    hs = m_cv & cr;
    if (hs) begin
      check("byte_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        oh = NR'(1) << e[15:8];
        check("core_data", 32'(m_cdat), 32'(e[7:0]));
        check("grant_owner", 32'(m_gnt), 32'(oh));
      end
    end
    if (m_pd != '0) begin
      check("pkt_done_after_core_done", 32'(prev_cd), 32'(1));
      check("pkt_done_expected", 32'(done_q.size() != 0), 32'(1));
      if (done_q.size() != 0) begin
        d  = done_q.pop_front();
        oh = NR'(1) << d;
        check("pkt_done", 32'(m_pd), 32'(oh));
      end
    end
    prev_cd = cd;
    acc = req_valid & m_rr;
    @(posedge tx_clk);
    #1;
    if (cd) begin
      cd       = 1'b0;
      cr       = 1'b1;
      in_frame = 1'b0;
    end else if (hs) begin
      cr       = 1'b0;
      in_frame = 1'b1;
      fcnt     = FRAME;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) cd = 1'b1;
    end
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        req_valid[i] = 1'b0;
        bpos[i]++;
        if (bpos[i] < bcnt[i]) bwait[i] = bgap[i][bpos[i]];
      end
      if (!req_valid[i] && bpos[i] < bcnt[i]) begin
        if (bwait[i] > 0) bwait[i]--;
        else begin
          req_valid[i]            = 1'b1;
          req_data[i*DW +: DW]    = bdata[i][bpos[i]];
          req_last[i]             = blast[i][bpos[i]];
        end
      end
    end
  endtask

  task automatic run(input string tag);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < BUDGET) begin
      cycle();
      n++;
    end
    check({tag, "_finished"}, 32'(n < BUDGET), 32'(1));
    repeat (3) cycle();
    check({tag, "_idle_grant"}, 32'(m_gnt), 32'(0));
    check({tag, "_idle_busy"}, 32'(m_busy), 32'(0));
  endtask

  initial begin
    int unsigned n;
    #1;

    // Single requester, three-byte packet.
    do_reset(1'b0);
    load(2, 8'hA1, 1'b0, 0); load(2, 8'hA2, 1'b0, 0); load(2, 8'hA3, 1'b1, 0);
    expect_byte(2, 8'hA1); expect_byte(2, 8'hA2); expect_byte(2, 8'hA3);
    done_q.push_back(2);
    run("single");

    // Round-robin from reset, then 0 vs 3 after 3 was last served.
    do_reset(1'b0);
    load(0, 8'h10, 1'b1, 0); load(1, 8'h11, 1'b1, 0); load(3, 8'h13, 1'b1, 0);
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(3, 8'h13);
    done_q.push_back(0); done_q.push_back(1); done_q.push_back(3);
    run("rr");
    load(3, 8'h23, 1'b1, 0); load(0, 8'h20, 1'b1, 0);
    expect_byte(0, 8'h20); expect_byte(3, 8'h23);
    done_q.push_back(0); done_q.push_back(3);
    run("rr_wrap");

    // Packet lock: req 1 waits for all of req 0's packet.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) load(0, 8'(8'hB0 + i), 1'(i == 3), 0);
    load(1, 8'hC0, 1'b1, 0);
    for (int i = 0; i < 4; i++) expect_byte(0, 8'(8'hB0 + i));
    expect_byte(1, 8'hC0);
    done_q.push_back(0); done_q.push_back(1);
    run("lock");

    // Fairness with MAX_PKT=2: r0 r0 r1 r0 r0 r0.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) load(0, 8'(8'hD0 + i), 1'(i == 4), 0);
    load(1, 8'hE0, 1'b1, 0);
    expect_byte(0, 8'hD0); expect_byte(0, 8'hD1); expect_byte(1, 8'hE0);
    expect_byte(0, 8'hD2); expect_byte(0, 8'hD3); expect_byte(0, 8'hD4);
    done_q.push_back(1); done_q.push_back(0);
    run("fair");

    // Stall inside a packet while req 2 is pending.
    do_reset(1'b0);
    load(0, 8'hF0, 1'b0, 0); load(0, 8'hF1, 1'b0, 20); load(0, 8'hF2, 1'b1, 0);
    load(2, 8'h70, 1'b1, 0);
    expect_byte(0, 8'hF0); expect_byte(0, 8'hF1); expect_byte(0, 8'hF2);
    expect_byte(2, 8'h70);
    done_q.push_back(0); done_q.push_back(2);
    run("stall");

    // Reset during WAIT_DONE, then priority restarts at requester 0.
    do_reset(1'b0);
    load(1, 8'h55, 1'b1, 0);
    expect_byte(1, 8'h55);
    n = 0;
    while (!in_frame && n < 100) begin
      cycle();
      n++;
    end
    check("midrst_in_frame", 32'(in_frame), 32'(1));
    repeat (3) cycle();
    check("midrst_busy_before", 32'(m_busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_grant", 32'(m_gnt), 32'(0));
    check("midrst_busy", 32'(m_busy), 32'(0));
    check("midrst_core_valid", 32'(m_cv), 32'(0));
    check("midrst_req_ready", 32'(m_rr), 32'(0));
    check("midrst_pkt_done", 32'(m_pd), 32'(0));
    do_reset(1'b0);
    load(1, 8'h61, 1'b1, 0); load(0, 8'h60, 1'b1, 0);
    expect_byte(0, 8'h60); expect_byte(1, 8'h61);
    done_q.push_back(0); done_q.push_back(1);
    run("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core (valid/ready/data byte interface plus a one-cycle done pulse) between NUM_REQ byte-stream requesters in the tx_clk domain.
- Arbitration is round-robin, with packet locking: a winner keeps the grant until its packet's last byte has completely left the line, or until a fairness byte limit is reached.
- Sits between the Avalon-side UART register/FIFO logic and the transmitter core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the transmitter core.
- MAX_PKT, 16, maximum bytes sent per grant before forced release (1..255).

Ports:
- tx_clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is the last of its packet
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high at a tx_clk edge
- core_valid  out  1  to transmitter core valid
- core_data  out  DATA_W  to transmitter core data
- core_ready  in  1  transmitter core can accept a byte
- core_done  in  1  one-cycle pulse at end of the stop bit
- grant  out  NUM_REQ  one-hot current owner; 0 when idle
- busy  out  1  high in any state other than IDLE
- pkt_done  out  NUM_REQ  one-cycle pulse when requester i's last byte finishes

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; grant, pkt_done, busy, core_valid, req_ready and core_data all 0.
  - Round-robin pointer last_gnt = NUM_REQ-1, so requester 0 has first priority.
  - Byte counter = 0.
- Reset mid-operation aborts everything immediately; there is no recovery of the in-flight byte.
- State machine (IDLE, ISSUE, WAIT_DONE):
  - IDLE:
    - If any req_valid is high, select the first set bit searching from last_gnt+1 upward, wrapping modulo NUM_REQ.
    - Register grant, go to ISSUE, clear the byte counter.
    - Arbitration latency: exactly 1 cycle from req_valid to grant.
  - ISSUE (owner g):
    - Combinational pass-through: core_valid=req_valid[g]; core_data=req_data slice g; req_ready[g]=core_ready.
    - All other req_ready bits are 0.
    - On handshake (req_valid[g] and core_ready): capture req_last[g] into last_r, increment the byte counter, go to WAIT_DONE.
    - With req_valid[g] low, stay in ISSUE indefinitely; the grant is held inside the packet.
  - WAIT_DONE:
    - core_valid=0; all req_ready=0.
    - core_done is ignored in every other state.
    - On core_done with last_r=1: pulse pkt_done[g] in the next cycle, set last_gnt=g, clear grant, go to IDLE.
    - On core_done with last_r=0 and counter==MAX_PKT: forced release. Set last_gnt=g, clear grant, go to IDLE, no pkt_done. The requester resumes its packet on a later grant.
    - Otherwise, on core_done: go to ISSUE, same owner.
- Requester rule: once req_valid[i] is asserted, req_data, req_last and req_valid stay stable until accepted. The arbiter does not check this.
- Simultaneous events:
  - A requester raising valid in the same cycle the grant is released competes in the next IDLE cycle.
  - core_ready high in WAIT_DONE is ignored.
  - The minimum gap between packets of different owners is one IDLE cycle.
- grant is one-hot or zero at all times. busy = (state != IDLE).

Test Plan:
- Single requester: NUM_REQ=4, req 2 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3), core model with a 10-cycle frame.
  -> core_data sequence A1, A2, A3; grant=4'b0100 throughout; one pkt_done[2] pulse after the third core_done; back to IDLE with grant=0.
- Round-robin: reqs 0, 1, 3 each hold a 1-byte packet (0x10, 0x11, 0x13) from the same cycle after reset.
  -> service order 0, 1, 3; next contention with 0 and 3 both pending grants 0.
- Packet lock: req 0 sends 4 bytes, req 1 valid throughout.
  -> all 4 bytes of req 0 go out before any byte of req 1; req_ready[1] stays 0 until req 0's pkt_done.
- Fairness: MAX_PKT=2, req 0 sends a 5-byte packet, req 1 sends 1 byte.
  -> order r0, r0, r1, r0, r0, r0 with no pkt_done at the forced release; pkt_done[1] once, then pkt_done[0] once.
- Stall inside packet: req 0 drops valid for 20 cycles between bytes while req 2 is pending.
  -> grant stays 4'b0001; core_valid=0 during the gap; req 2 is served only after req 0's last byte.
- Reset mid-frame: assert reset_n=0 during WAIT_DONE.
  -> grant, busy, core_valid, req_ready and pkt_done are 0 immediately; after release, requester 0 has priority.
